// File: rtl/brushless_commutator.sv
// Brushless commutation stage: hall sync and per-PWM-period sampling, commutation table, duty, stall
// and rotation-period tracking. Defining REGEN_BRAKE_EN adds the regenerative brake path.
module brushless_commutator #(
    parameter int          STALL_PERIODS = 1024,
    parameter int          PERIOD_W      = 20,
    parameter logic [10:0] BRAKE_DUTY    = 11'h600
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hallGrn,
    input  logic                hallYlw,
    input  logic                hallBlu,
    input  logic                PWM_synch,
    input  logic [11:0]         drv_mag,
    input  logic                brake_n,
    output logic [1:0]          selGrn,
    output logic [1:0]          selYlw,
    output logic [1:0]          selBlu,
    output logic [10:0]         duty,
    output logic                stall,
    output logic                hall_err,
    output logic [PERIOD_W-1:0] rot_period
);
    localparam int                  SCNT_W     = $clog2(STALL_PERIODS + 1);
    localparam logic [SCNT_W-1:0]   STALL_LAST = SCNT_W'(STALL_PERIODS - 1);
    localparam logic [SCNT_W-1:0]   STALL_FULL = SCNT_W'(STALL_PERIODS);
    localparam logic [PERIOD_W-1:0] COUNT_MAX  = {PERIOD_W{1'b1}};

    function automatic logic hall_ok(input logic [2:0] h);
        return (h != 3'b000) && (h != 3'b111);
    endfunction

    // Packed as {Grn, Ylw, Blu}; 10 forward, 01 reverse, 00 coast.
    function automatic logic [5:0] commutate(input logic [2:0] h);
        logic [5:0] s;
        case (h)
            3'b101:  s = 6'b10_01_00;
            3'b100:  s = 6'b10_00_01;
            3'b110:  s = 6'b00_10_01;
            3'b010:  s = 6'b01_10_00;
            3'b011:  s = 6'b01_00_10;
            3'b001:  s = 6'b00_01_10;
            default: s = 6'b00_00_00;
        endcase
        return s;
    endfunction

    logic [2:0]          sync1_q, sync1_d;
    logic [2:0]          sync2_q, sync2_d;
    logic [2:0]          hall_state_q, hall_state_d;
    logic                upd_q, upd_d;
    logic [11:0]         mag_q, mag_d;
    logic [PERIOD_W-1:0] count_q, count_d;
    logic [PERIOD_W-1:0] rot_period_q, rot_period_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic                stall_q, stall_d;
    logic [5:0]          sel_q, sel_d;
    logic [10:0]         duty_q, duty_d;
    logic                hall_err_q, hall_err_d;
    logic [PERIOD_W-1:0] count_inc;
    logic                hall_change;
    logic                valid_trans;
    logic                brake_req;
    logic                brake_active;

`ifdef REGEN_BRAKE_EN
    logic brake_q, brake_d;

    assign brake_req    = !brake_n;
    assign brake_active = brake_q;

    always_comb begin
        brake_d = brake_q;
        if (PWM_synch) begin
            brake_d = !brake_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brake_q <= 1'b0;
        end else begin
            brake_q <= brake_d;
        end
    end
`else
    // brake_n has no function in this build.
    logic brake_unused;

    assign brake_req    = 1'b0;
    assign brake_active = 1'b0;
    assign brake_unused = brake_n;
`endif

    // Sampling, transition tracking and stall detection all act on the PWM_synch cycle.
    always_comb begin
        sync1_d      = {hallBlu, hallYlw, hallGrn};
        sync2_d      = sync1_q;
        upd_d        = PWM_synch;
        hall_state_d = hall_state_q;
        mag_d        = mag_q;
        rot_period_d = rot_period_q;
        scnt_d       = scnt_q;
        stall_d      = stall_q;
        count_inc    = (count_q == COUNT_MAX) ? count_q : count_q + PERIOD_W'(1);
        count_d      = count_inc;
        hall_change  = (sync2_q != hall_state_q) && hall_ok(sync2_q);
        valid_trans  = hall_change && hall_ok(hall_state_q);

        if (PWM_synch) begin
            hall_state_d = sync2_q;
            mag_d        = drv_mag;

            // Entering a valid state from an invalid one restarts timing without a measurement.
            if (hall_change) begin
                count_d = '0;
                if (valid_trans) begin
                    rot_period_d = count_inc;
                end
            end

            if (drv_mag == 12'd0) begin
                scnt_d  = '0;
                stall_d = 1'b0;
            end else if (brake_req) begin
                scnt_d = scnt_q;
            end else if (valid_trans) begin
                scnt_d = '0;
            end else if (scnt_q >= STALL_LAST) begin
                scnt_d  = STALL_FULL;
                stall_d = 1'b1;
            end else begin
                scnt_d = scnt_q + SCNT_W'(1);
            end
        end
    end

    // Drive outputs refresh one cycle after the sample so they see the new state.
    always_comb begin
        sel_d      = sel_q;
        duty_d     = duty_q;
        hall_err_d = hall_err_q;

        if (upd_q) begin
            hall_err_d = !hall_ok(hall_state_q);
            if (stall_q) begin
                sel_d  = '0;
                duty_d = '0;
            end else if (brake_active) begin
                sel_d  = 6'b01_01_01;
                duty_d = BRAKE_DUTY;
            end else if (!hall_ok(hall_state_q) || (mag_q == 12'd0)) begin
                sel_d  = '0;
                duty_d = '0;
            end else begin
                sel_d  = commutate(hall_state_q);
                duty_d = 11'h400 + {1'b0, mag_q[11:2]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            hall_state_q <= '0;
            upd_q        <= 1'b0;
            mag_q        <= '0;
            count_q      <= '0;
            rot_period_q <= '0;
            scnt_q       <= '0;
            stall_q      <= 1'b0;
            sel_q        <= '0;
            duty_q       <= '0;
            hall_err_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            hall_state_q <= hall_state_d;
            upd_q        <= upd_d;
            mag_q        <= mag_d;
            count_q      <= count_d;
            rot_period_q <= rot_period_d;
            scnt_q       <= scnt_d;
            stall_q      <= stall_d;
            sel_q        <= sel_d;
            duty_q       <= duty_d;
            hall_err_q   <= hall_err_d;
        end
    end

    assign selGrn     = sel_q[5:4];
    assign selYlw     = sel_q[3:2];
    assign selBlu     = sel_q[1:0];
    assign duty       = duty_q;
    assign stall      = stall_q;
    assign hall_err   = hall_err_q;
    assign rot_period = rot_period_q;

endmodule
